// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, no parity, one start bit, one stop bit, LSB first.
// The serial input is double-flopped, then sampled mid-bit by a counter-driven FSM.
// Good frames update o_data and pulse o_rx_valid for one cycle. A low stop bit pulses
// o_frame_err for one cycle and waits for the line to return high before re-arming.
//
// Ports:
//   i_clk       - system clock, rising edge
//   i_rst       - synchronous active-high reset
//   i_rx        - asynchronous serial input, idles high
//   o_data      - last correctly framed byte, held until the next good frame
//   o_rx_valid  - one-cycle strobe, o_data just updated
//   o_frame_err - one-cycle strobe, stop bit sampled low
//   o_active    - high while a frame is being received (START, DATA, STOP)
module uart_rx #(
  parameter int unsigned CLK_FREQ  = 300000000,
  parameter int unsigned BAUD_RATE = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_active
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CntW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e          state_q, state_d;
  logic            rx_meta_q;
  logic            rx_s_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  logic            bit_done;
  logic            half_done;

  assign bit_done  = (cnt_q == BitLast);
  assign half_done = (cnt_q == HalfLast);

  // State and datapath registers, including the two-flop synchronizer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        // Mid start bit: a high line here means the falling edge was a glitch.
        if (half_done) state_d = rx_s_q ? StIdle : StData;
      end
      StData: begin
        if (bit_done && (idx_q == 3'd7)) state_d = StStop;
      end
      StStop: begin
        // Leaving at mid stop bit allows a start edge right after it.
        if (bit_done) state_d = rx_s_q ? StIdle : StWaitHigh;
      end
      StWaitHigh: begin
        // Hold off until the line goes high so a break is not read as 0x00 frames.
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Counter, shift register and output strobe logic.
  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
      end
      StStart: begin
        cnt_d = half_done ? '0 : cnt_q + 1'b1;
      end
      StData: begin
        if (bit_done) begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = '0;
          idx_d          = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StStop: begin
        if (bit_done) begin
          cnt_d = '0;
          if (rx_s_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWaitHigh: begin
        cnt_d = '0;
        idx_d = '0;
      end
      default: begin
        cnt_d = '0;
        idx_d = '0;
      end
    endcase
  end

  assign o_active    = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
  assign o_data      = data_q;
  assign o_rx_valid  = valid_q;
  assign o_frame_err = err_q;

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int unsigned ClkFreq = 1600000;
  localparam int unsigned Baud    = 100000;
  localparam int          C       = 16;
  localparam int          H       = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] o_data;
  logic       o_rx_valid;
  logic       o_frame_err;
  logic       o_active;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int last_t0 = 0;
  logic [7:0] last_good = 8'h00;

  logic [7:0] sb[$];
  int         vtimes[$];

  uart_rx #(
    .CLK_FREQ (ClkFreq),
    .BAUD_RATE(Baud)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rx       (rx),
    .o_data     (o_data),
    .o_rx_valid (o_rx_valid),
    .o_frame_err(o_frame_err),
    .o_active   (o_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: every valid strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_rx_valid || o_frame_err) begin
        checks++;
        if (o_rx_valid && o_frame_err) begin
          errors++;
          $display("FAIL strobe_exclusive: valid=%0b frame_err=%0b, required not both",
                   o_rx_valid, o_frame_err);
        end
      end
      if (o_rx_valid) begin
        valid_cnt++;
        vtimes.push_back(cyc);
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: got byte 0x%02h at cycle %0d, none expected",
                   o_data, cyc);
        end else begin
          logic [7:0] exp;
          exp = sb.pop_front();
          if (o_data !== exp) begin
            errors++;
            $display("FAIL rx_data: got 0x%02h, required 0x%02h", o_data, exp);
          end
        end
      end
      if (o_frame_err) err_cnt++;
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (C) @(negedge clk);
  endtask

  // Called at a negedge; t0 is the next rising edge.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit expect_ok);
    if (expect_ok) sb.push_back(b);
    last_t0 = cyc + 1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic wait_drain(input int budget, input string name);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes still pending, required 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    checks += 4;
    if (o_data !== 8'h00) begin
      errors++; $display("FAIL reset_data: got 0x%02h, required 0x00", o_data);
    end
    if (o_rx_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %0b, required 0", o_rx_valid);
    end
    if (o_frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_frame_err: got %0b, required 0", o_frame_err);
    end
    if (o_active !== 1'b0) begin
      errors++; $display("FAIL reset_active: got %0b, required 0", o_active);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (o_active !== 1'b0) begin
      errors++; $display("FAIL idle_active: got %0b, required 0", o_active);
    end
  endtask

  task automatic test_single_byte();
    int e0;
    int n0;
    e0 = err_cnt;
    n0 = vtimes.size();
    checks++;
    if (o_active !== 1'b0) begin
      errors++; $display("FAIL single_active_before: got %0b, required 0", o_active);
    end
    send_frame(8'hA5, 1'b1, 1'b1);
    wait_drain(200, "single");
    last_good = 8'hA5;
    checks += 4;
    if (vtimes.size() != n0 + 1) begin
      errors++; $display("FAIL single_count: got %0d pulses, required 1", vtimes.size() - n0);
    end else if (vtimes[n0] != last_t0 + 2 + H + 9 * C) begin
      errors++;
      $display("FAIL single_latency: pulse at edge %0d, required %0d",
               vtimes[n0], last_t0 + 2 + H + 9 * C);
    end
    if (err_cnt != e0) begin
      errors++; $display("FAIL single_frame_err: got %0d pulses, required 0", err_cnt - e0);
    end
    if (o_data !== 8'hA5) begin
      errors++; $display("FAIL single_data_hold: got 0x%02h, required 0xa5", o_data);
    end
    if (o_active !== 1'b0) begin
      errors++; $display("FAIL single_active_after: got %0b, required 0", o_active);
    end
  endtask

  task automatic test_start_glitch();
    int act;
    int v0;
    int e0;
    act = 0;
    v0  = valid_cnt;
    e0  = err_cnt;
    rx = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (o_active) act++;
    end
    rx = 1'b1;
    repeat (37) begin
      @(negedge clk);
      if (o_active) act++;
    end
    checks += 2;
    if (act != H) begin
      errors++; $display("FAIL glitch_active_cycles: got %0d, required %0d", act, H);
    end
    if (valid_cnt != v0 || err_cnt != e0) begin
      errors++;
      $display("FAIL glitch_pulses: got valid=%0d err=%0d, required 0 0",
               valid_cnt - v0, err_cnt - e0);
    end
    send_frame(8'h3C, 1'b1, 1'b1);
    wait_drain(200, "glitch_follow");
    last_good = 8'h3C;
  endtask

  task automatic test_frame_err();
    int v0;
    int e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(8'h81, 1'b0, 1'b0);
    checks += 2;
    if (err_cnt != e0 + 1) begin
      errors++; $display("FAIL ferr_pulse: got %0d pulses, required 1", err_cnt - e0);
    end
    if (o_data !== last_good) begin
      errors++; $display("FAIL ferr_data_hold: got 0x%02h, required 0x%02h", o_data, last_good);
    end
    rx = 1'b0;
    repeat (100) @(negedge clk);
    checks += 2;
    if (err_cnt != e0 + 1 || valid_cnt != v0) begin
      errors++;
      $display("FAIL break_pulses: got valid=%0d err=%0d, required 0 1",
               valid_cnt - v0, err_cnt - e0);
    end
    if (o_active !== 1'b0) begin
      errors++; $display("FAIL break_active: got %0b, required 0", o_active);
    end
    rx = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h42, 1'b1, 1'b1);
    wait_drain(200, "ferr_follow");
    last_good = 8'h42;
    checks++;
    if (valid_cnt != v0 + 1 || err_cnt != e0 + 1) begin
      errors++;
      $display("FAIL ferr_totals: got valid=%0d err=%0d, required 1 1",
               valid_cnt - v0, err_cnt - e0);
    end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = vtimes.size();
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h55, 1'b1, 1'b1);
    wait_drain(200, "b2b");
    last_good = 8'h55;
    checks++;
    if (vtimes.size() != n0 + 3) begin
      errors++; $display("FAIL b2b_count: got %0d pulses, required 3", vtimes.size() - n0);
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (vtimes[n0 + i] - vtimes[n0 + i - 1] != 10 * C) begin
          errors++;
          $display("FAIL b2b_spacing: got %0d cycles, required %0d",
                   vtimes[n0 + i] - vtimes[n0 + i - 1], 10 * C);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    int e0;
    logic [7:0] b;
    b  = 8'hF0;
    v0 = valid_cnt;
    e0 = err_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(b[i]);
    rx = b[4];
    repeat (C / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks += 4;
    if (o_data !== 8'h00) begin
      errors++; $display("FAIL midrst_data: got 0x%02h, required 0x00", o_data);
    end
    if (o_rx_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_valid: got %0b, required 0", o_rx_valid);
    end
    if (o_frame_err !== 1'b0) begin
      errors++; $display("FAIL midrst_frame_err: got %0b, required 0", o_frame_err);
    end
    if (o_active !== 1'b0) begin
      errors++; $display("FAIL midrst_active: got %0b, required 0", o_active);
    end
    rst = 1'b0;
    last_good = 8'h00;
    repeat (C / 2 - 1) @(negedge clk);
    for (int i = 5; i < 8; i++) drive_bit(b[i]);
    drive_bit(1'b1);
    send_frame(8'h12, 1'b1, 1'b1);
    wait_drain(200, "midrst_follow");
    last_good = 8'h12;
    checks++;
    if (valid_cnt != v0 + 1 || err_cnt != e0) begin
      errors++;
      $display("FAIL midrst_totals: got valid=%0d err=%0d, required 1 0",
               valid_cnt - v0, err_cnt - e0);
    end
  endtask

  task automatic test_loopback();
    int v0;
    int e0;
    v0 = valid_cnt;
    e0 = err_cnt;
    for (int i = 0; i < 256; i++) begin
      send_frame(8'(i), 1'b1, 1'b1);
      drive_bit(1'b1);
    end
    wait_drain(400, "loopback");
    checks += 2;
    if (valid_cnt != v0 + 256) begin
      errors++; $display("FAIL loopback_count: got %0d pulses, required 256", valid_cnt - v0);
    end
    if (err_cnt != e0) begin
      errors++; $display("FAIL loopback_frame_err: got %0d pulses, required 0", err_cnt - e0);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_start_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
